// File: rtl/memory_types_pkg.sv
// Shared memory packet encodings used by the requesters, the arbiter and the memory model.
package memory_types_pkg;

    localparam int unsigned MEM_TYPE_W = 3;
    localparam int unsigned MEM_LEN_W  = 2;

    typedef enum logic [MEM_TYPE_W-1:0] {
        READ  = 3'd0,
        WRITE = 3'd1
    } mem_pkt_type_e;

    typedef enum logic [MEM_LEN_W-1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_len_e;

endpackage

// File: rtl/mem_id_fifo.sv
// Small FIFO of requester IDs; remembers which port owns each outstanding memory request.
module mem_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_id_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o  = (count_q == CntW'(DEPTH));
        empty_o = (count_q == '0);
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of per-port memory requests onto one channel, with in-order response
// routing back to the requester via an ID FIFO.
module mem_req_arbiter
    import memory_types_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_val,
    output logic [NUM_PORTS-1:0]             req_rdy,
    input  logic [NUM_PORTS*MEM_TYPE_W-1:0]  req_type,
    input  logic [NUM_PORTS*ADDR_W-1:0]      req_addr,
    input  logic [NUM_PORTS*MEM_LEN_W-1:0]   req_len,
    input  logic [NUM_PORTS*DATA_W-1:0]      req_data,
    output logic                             mem_req_val,
    input  logic                             mem_req_rdy,
    output logic [MEM_TYPE_W-1:0]            mem_req_type,
    output logic [ADDR_W-1:0]                mem_req_addr,
    output logic [MEM_LEN_W-1:0]             mem_req_len,
    output logic [DATA_W-1:0]                mem_req_data,
    input  logic                             mem_resp_val,
    output logic                             mem_resp_rdy,
    input  logic [MEM_TYPE_W-1:0]            mem_resp_type,
    input  logic [DATA_W-1:0]                mem_resp_data,
    output logic [NUM_PORTS-1:0]             resp_val,
    input  logic [NUM_PORTS-1:0]             resp_rdy,
    output logic [MEM_TYPE_W-1:0]            resp_type,
    output logic [DATA_W-1:0]                resp_data
);

    localparam int unsigned PortW = $clog2(NUM_PORTS);
    localparam int unsigned CntW  = $clog2(MAX_INFLIGHT + 1);
    localparam logic [PortW-1:0] LastPort = PortW'(NUM_PORTS - 1);

    logic [PortW-1:0]      ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]  gnt;
    logic [PortW-1:0]      gnt_idx;
    logic                  can_accept, accept;

    logic                  out_val_q, out_val_d;
    logic [MEM_TYPE_W-1:0] out_type_q, out_type_d, sel_type;
    logic [ADDR_W-1:0]     out_addr_q, out_addr_d, sel_addr;
    logic [MEM_LEN_W-1:0]  out_len_q, out_len_d, sel_len;
    logic [DATA_W-1:0]     out_data_q, out_data_d, sel_data;

    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [PortW-1:0]      fifo_head;
    logic [CntW-1:0]       fifo_count;
    logic                  unused_fifo_count;

    assign unused_fifo_count = ^fifo_count;

    // Rotating search starting at ptr; idx carries one spare bit for the wrap.
    always_comb begin
        logic [PortW:0] idx;
        logic           found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, ptr_q} + (PortW+1)'(k);
            if (idx >= (PortW+1)'(NUM_PORTS)) idx = idx - (PortW+1)'(NUM_PORTS);
            if (!found && req_val[idx[PortW-1:0]]) begin
                found                   = 1'b1;
                gnt[idx[PortW-1:0]]     = 1'b1;
                gnt_idx                 = idx[PortW-1:0];
            end
        end
    end

    always_comb begin
        sel_type = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                sel_type = req_type[MEM_TYPE_W*i +: MEM_TYPE_W];
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                sel_len  = req_len[MEM_LEN_W*i +: MEM_LEN_W];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        can_accept = !rst && (!out_val_q || mem_req_rdy) && !fifo_full;
        req_rdy    = can_accept ? gnt : '0;
        accept     = can_accept && (gnt != '0);

        ptr_d      = ptr_q;
        out_val_d  = out_val_q;
        out_type_d = out_type_q;
        out_addr_d = out_addr_q;
        out_len_d  = out_len_q;
        out_data_d = out_data_q;
        if (accept) begin
            ptr_d      = (gnt_idx == LastPort) ? '0 : gnt_idx + 1'b1;
            out_val_d  = 1'b1;
            out_type_d = sel_type;
            out_addr_d = sel_addr;
            out_len_d  = sel_len;
            out_data_d = sel_data;
        end else if (mem_req_rdy) begin
            out_val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            out_val_q  <= 1'b0;
            out_type_q <= '0;
            out_addr_q <= '0;
            out_len_q  <= '0;
            out_data_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            out_val_q  <= out_val_d;
            out_type_q <= out_type_d;
            out_addr_q <= out_addr_d;
            out_len_q  <= out_len_d;
            out_data_q <= out_data_d;
        end
    end

    // Outputs are forced low while reset is held, before the first reset edge lands.
    always_comb begin
        mem_req_val  = out_val_q && !rst;
        mem_req_type = rst ? '0 : out_type_q;
        mem_req_addr = rst ? '0 : out_addr_q;
        mem_req_len  = rst ? '0 : out_len_q;
        mem_req_data = rst ? '0 : out_data_q;
    end

    // With nothing outstanding, stray responses are drained and dropped.
    always_comb begin
        resp_val     = '0;
        mem_resp_rdy = !rst;
        if (!fifo_empty && !rst) begin
            resp_val     = NUM_PORTS'(mem_resp_val) << fifo_head;
            mem_resp_rdy = resp_rdy[fifo_head];
        end
        fifo_pop  = mem_resp_val && mem_resp_rdy && !fifo_empty;
        resp_type = mem_resp_type;
        resp_data = mem_resp_data;
    end

    mem_id_fifo #(
        .WIDTH (PortW),
        .DEPTH (MAX_INFLIGHT)
    ) u_id_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (accept),
        .push_id_i (gnt_idx),
        .pop_i     (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_mem_req_arbiter;
    import memory_types_pkg::*;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MI = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_val = '0;
    logic [NP-1:0]     req_rdy;
    logic [NP*3-1:0]   req_type = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*2-1:0]   req_len = '0;
    logic [NP*DW-1:0]  req_data = '0;
    logic              mem_req_val;
    logic              mem_req_rdy = 1'b0;
    logic [2:0]        mem_req_type;
    logic [AW-1:0]     mem_req_addr;
    logic [1:0]        mem_req_len;
    logic [DW-1:0]     mem_req_data;
    logic              mem_resp_val = 1'b0;
    logic              mem_resp_rdy;
    logic [2:0]        mem_resp_type = '0;
    logic [DW-1:0]     mem_resp_data = '0;
    logic [NP-1:0]     resp_val;
    logic [NP-1:0]     resp_rdy = '0;
    logic [2:0]        resp_type;
    logic [DW-1:0]     resp_data;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .NUM_PORTS    (NP),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_type      (req_type),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_data      (req_data),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_type  (mem_req_type),
        .mem_req_addr  (mem_req_addr),
        .mem_req_len   (mem_req_len),
        .mem_req_data  (mem_req_data),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_rdy  (mem_resp_rdy),
        .mem_resp_type (mem_resp_type),
        .mem_resp_data (mem_resp_data),
        .resp_val      (resp_val),
        .resp_rdy      (resp_rdy),
        .resp_type     (resp_type),
        .resp_data     (resp_data)
    );

    typedef struct packed {
        logic [2:0]    typ;
        logic [AW-1:0] addr;
        logic [1:0]    len;
        logic [DW-1:0] data;
    } pkt_t;

    // Stimulus side: per-port packet queues and a memory that answers what it has received.
    pkt_t          pq [NP][$];
    int            mem_pend;
    int            resp_mode;   // 0 manual, 1 answer whenever possible, 2 answer randomly
    logic [AW-1:0] fwd_log[$];
    int            fwd_cyc[$];
    int            cyc;

    // Reference model: packets awaiting forwarding, ports awaiting responses, next priority.
    pkt_t          m_sb[$];
    int            m_outst[$];
    int            m_ptr;
    bit            m_acc, m_fwd, m_resp;
    int            m_g;
    pkt_t          m_pkt;

    logic [NP-1:0] hs_req;
    logic          hs_fwd, hs_resp;
    int            total, bad;

    function automatic pkt_t mk(input logic [2:0] t, input logic [AW-1:0] a,
                                input logic [1:0] l, input logic [DW-1:0] d);
        pkt_t p;
        p.typ = t; p.addr = a; p.len = l; p.data = d;
        return p;
    endfunction

    function automatic pkt_t rnd_pkt();
        return mk(3'($urandom), $urandom, 2'($urandom), $urandom);
    endfunction

    function automatic bit idle();
        bit e = (m_sb.size() == 0) && (m_outst.size() == 0);
        for (int i = 0; i < NP; i++) if (pq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req_val[i] = (pq[i].size() != 0);
            if (pq[i].size() != 0) begin
                req_type[3*i +: 3]   = pq[i][0].typ;
                req_addr[AW*i +: AW] = pq[i][0].addr;
                req_len[2*i +: 2]    = pq[i][0].len;
                req_data[DW*i +: DW] = pq[i][0].data;
            end
        end
        if (resp_mode != 0) begin
            mem_resp_val  = (mem_pend > 0) && (resp_mode == 1 || ($urandom % 2) == 0);
            mem_resp_type = 3'($urandom);
            mem_resp_data = $urandom;
        end
    endtask

    task automatic check_reset();
        check("rst_req_rdy", req_rdy, 0);
        check("rst_mem_req_val", mem_req_val, 0);
        check("rst_mem_req_type", mem_req_type, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_mem_req_len", mem_req_len, 0);
        check("rst_mem_req_data", mem_req_data, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_mem_resp_rdy", mem_resp_rdy, 0);
    endtask

    task automatic model_check();
        logic [NP-1:0] exp_rdy, exp_rv;
        logic          exp_mrr;
        bit            can;
        int            h;
        m_g = -1;
        for (int k = 0; k < NP; k++) begin
            if (m_g < 0 && req_val[(m_ptr + k) % NP]) m_g = (m_ptr + k) % NP;
        end
        can = (m_sb.size() == 0 || mem_req_rdy) && (m_outst.size() < MI);
        exp_rdy = '0;
        if (m_g >= 0 && can) exp_rdy[m_g] = 1'b1;
        m_acc = (exp_rdy != '0);
        if (m_acc) m_pkt = mk(req_type[3*m_g +: 3], req_addr[AW*m_g +: AW],
                              req_len[2*m_g +: 2], req_data[DW*m_g +: DW]);
        check("req_rdy", req_rdy, exp_rdy);
        check("mem_req_val", mem_req_val, (m_sb.size() != 0));
        if (m_sb.size() != 0) begin
            check("mem_req_type", mem_req_type, m_sb[0].typ);
            check("mem_req_addr", mem_req_addr, m_sb[0].addr);
            check("mem_req_len", mem_req_len, m_sb[0].len);
            check("mem_req_data", mem_req_data, m_sb[0].data);
        end
        m_fwd = (m_sb.size() != 0) && mem_req_rdy;
        exp_rv = '0;
        if (m_outst.size() != 0) begin
            h = m_outst[0];
            if (mem_resp_val) exp_rv[h] = 1'b1;
            exp_mrr = resp_rdy[h];
            m_resp  = mem_resp_val && resp_rdy[h];
        end else begin
            exp_mrr = 1'b1;
            m_resp  = 1'b0;
        end
        check("resp_val", resp_val, exp_rv);
        check("mem_resp_rdy", mem_resp_rdy, exp_mrr);
        check("resp_type", resp_type, mem_resp_type);
        check("resp_data", resp_data, mem_resp_data);
    endtask

    task automatic tick_pre();
        drive();
        #1;
        if (rst) check_reset();
        else model_check();
        hs_req  = req_val & req_rdy;
        hs_fwd  = mem_req_val && mem_req_rdy;
        hs_resp = mem_resp_val && mem_resp_rdy;
        if (hs_fwd) begin
            fwd_log.push_back(mem_req_addr);
            fwd_cyc.push_back(cyc);
        end
    endtask

    task automatic tick_post();
        @(posedge clk);
        if (rst) begin
            m_sb.delete();
            m_outst.delete();
            m_ptr    = 0;
            mem_pend = 0;
        end else begin
            if (m_fwd) void'(m_sb.pop_front());
            if (m_acc) begin
                m_sb.push_back(m_pkt);
                m_outst.push_back(m_g);
                m_ptr = (m_g + 1) % NP;
            end
            if (m_resp) void'(m_outst.pop_front());
            for (int i = 0; i < NP; i++) if (hs_req[i]) void'(pq[i].pop_front());
            if (hs_fwd) mem_pend++;
            if (hs_resp && mem_pend > 0) mem_pend--;
        end
        cyc++;
        #1;
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic drain();
        int k;
        mem_req_rdy = 1'b1;
        resp_rdy    = '1;
        resp_mode   = 1;
        k = 0;
        while (!idle() && k < 200) begin
            tick();
            k++;
        end
        check("drain_done", idle(), 1);
    endtask

    initial begin
        logic [AW-1:0] exp_seq [4];
        int c0;
        total = 0; bad = 0; cyc = 0; mem_pend = 0; m_ptr = 0;
        m_acc = 0; m_fwd = 0; m_resp = 0; m_g = -1;

        // Reset with every port requesting; then ptr=0 grants port 0 first.
        exp_seq[0] = 32'h10; exp_seq[1] = 32'h20; exp_seq[2] = 32'h14; exp_seq[3] = 32'h24;
        pq[0].push_back(mk(READ, 32'h10, WORD, $urandom));
        pq[0].push_back(mk(READ, 32'h14, WORD, $urandom));
        pq[1].push_back(mk(READ, 32'h20, WORD, $urandom));
        pq[1].push_back(mk(READ, 32'h24, WORD, $urandom));
        rst = 1'b1; mem_req_rdy = 1'b1; resp_rdy = '1; resp_mode = 1;
        tick();
        tick();
        rst = 1'b0;
        c0 = cyc;
        tick_pre();
        check("t1_req_rdy_after_reset", req_rdy, 2'b01);
        check("t1_mem_req_val_after_reset", mem_req_val, 0);
        tick_post();

        // Alternating full-throughput stream.
        drain();
        while (fwd_log.size() < 4) begin
            fwd_log.push_back('x);
            fwd_cyc.push_back(-1);
        end
        for (int k = 0; k < 4; k++) begin
            check("t2_addr_order", fwd_log[k], exp_seq[k]);
            check("t2_fwd_cycle", fwd_cyc[k], c0 + 1 + k);
        end

        // Back-pressure holds the output register and blocks grants.
        fwd_log.delete(); fwd_cyc.delete();
        resp_mode = 0; mem_resp_val = 1'b0;
        pq[0].push_back(mk(READ, 32'h40, WORD, $urandom));
        pq[1].push_back(mk(WRITE, 32'h50, HALF, $urandom));
        tick();
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_pre();
            check("t3_stall_val", mem_req_val, 1);
            check("t3_stall_addr", mem_req_addr, 32'h40);
            check("t3_stall_req_rdy", req_rdy, 0);
            tick_post();
        end
        mem_req_rdy = 1'b1;
        tick_pre();
        check("t3_release_req_rdy", req_rdy, 2'b10);
        tick_post();
        tick_pre();
        check("t3_next_addr", mem_req_addr, 32'h50);
        tick_post();
        check("t3_fwd_count", fwd_log.size(), 2);
        if (fwd_log.size() != 0) check("t3_fwd_first", fwd_log[0], 32'h40);
        drain();

        // Outstanding limit: fifth READ waits for a pop, not just the pop cycle.
        resp_mode = 0; mem_resp_val = 1'b0;
        for (int k = 0; k < 5; k++) pq[0].push_back(mk(READ, 32'h300 + 32'(4*k), WORD, 0));
        for (int k = 0; k < 4; k++) tick();
        tick_pre();
        check("t4_full_stall", req_rdy, 0);
        tick_post();
        mem_resp_val = 1'b1; mem_resp_type = READ; mem_resp_data = $urandom;
        tick_pre();
        check("t4_pop_cycle_req_rdy", req_rdy, 0);
        check("t4_pop_resp_val", resp_val, 2'b01);
        tick_post();
        mem_resp_val = 1'b0;
        tick_pre();
        check("t4_after_pop_req_rdy", req_rdy, 2'b01);
        tick_post();
        drain();

        // Routing of mixed READ/WRITE responses with per-port back-pressure.
        resp_mode = 0; mem_resp_val = 1'b0;
        pq[1].push_back(mk(READ, 32'h100, WORD, 0));
        pq[0].push_back(mk(WRITE, 32'h200, WORD, 32'hDEADBEEF));
        for (int k = 0; k < 3; k++) tick();
        mem_resp_val = 1'b1; mem_resp_type = READ; mem_resp_data = 32'hCAFEF00D;
        resp_rdy = 2'b01;
        for (int k = 0; k < 2; k++) begin
            tick_pre();
            check("t5_read_resp_val", resp_val, 2'b10);
            check("t5_held_mem_resp_rdy", mem_resp_rdy, 0);
            check("t5_read_data", resp_data, 32'hCAFEF00D);
            tick_post();
        end
        resp_rdy = 2'b11;
        tick_pre();
        check("t5_read_accept", mem_resp_rdy, 1);
        tick_post();
        mem_resp_type = WRITE; mem_resp_data = '0;
        tick_pre();
        check("t5_write_resp_val", resp_val, 2'b01);
        check("t5_write_type", resp_type, WRITE);
        tick_post();
        mem_resp_val = 1'b0;
        drain();

        // Reset with three in flight and a packet parked in the output register.
        resp_mode = 0; mem_resp_val = 1'b0; mem_req_rdy = 1'b1;
        pq[0].push_back(mk(READ, 32'h500, WORD, 0));
        pq[0].push_back(mk(READ, 32'h504, WORD, 0));
        pq[1].push_back(mk(READ, 32'h600, WORD, 0));
        for (int k = 0; k < 3; k++) tick();
        pq[0].push_back(mk(READ, 32'h700, BYTE, 0));
        pq[1].push_back(mk(READ, 32'h800, BYTE, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_resp_val = 1'b1; mem_resp_type = READ; mem_resp_data = $urandom;
        tick_pre();
        check("t6_mem_req_val", mem_req_val, 0);
        check("t6_ptr_zero_grant", req_rdy, 2'b01);
        check("t6_stray_resp_val", resp_val, 0);
        check("t6_stray_mem_resp_rdy", mem_resp_rdy, 1);
        tick_post();
        mem_resp_val = 1'b0;
        drain();

        // Random traffic.
        resp_mode = 2;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NP; i++) begin
                if (pq[i].size() < 2 && ($urandom % 3) == 0) pq[i].push_back(rnd_pkt());
            end
            mem_req_rdy = (($urandom % 4) != 0);
            resp_rdy    = NP'($urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- N-port round-robin arbiter that merges memory request packets from NUM_PORTS requesters onto a single memory request channel.
- Routes in-order memory responses back to the originating port.
- Sits between the core's fetch/load-store units and the memory model or cache.
- Generalises the fixed 32-bit memory packet format to parametrised address/data widths, multiple channels and outstanding-transaction tracking.

Parameters:
NUM_PORTS, 2, number of requester channels (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_INFLIGHT, 4, max outstanding requests awaiting response (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req_val  in  NUM_PORTS  per-port request valid
req_rdy  out  NUM_PORTS  per-port request ready
req_type  in  NUM_PORTS*3  per-port packet type (mem_pkt_type_e; port i at [3i+:3])
req_addr  in  NUM_PORTS*ADDR_W  per-port address
req_len  in  NUM_PORTS*2  per-port length (0 byte, 1 half, 2 word, 3 reserved)
req_data  in  NUM_PORTS*DATA_W  per-port write data
mem_req_val  out  1  memory request valid
mem_req_rdy  in  1  memory request ready
mem_req_type  out  3  forwarded type
mem_req_addr  out  ADDR_W  forwarded address
mem_req_len  out  2  forwarded length
mem_req_data  out  DATA_W  forwarded data
mem_resp_val  in  1  memory response valid (in request order)
mem_resp_rdy  out  1  memory response ready
mem_resp_type  in  3  response type
mem_resp_data  in  DATA_W  response data (read data; don't-care for WRITE)
resp_val  out  NUM_PORTS  per-port response valid (one-hot or zero)
resp_rdy  in  NUM_PORTS  per-port response ready
resp_type  out  3  response type, broadcast to all ports
resp_data  out  DATA_W  response data, broadcast to all ports

Behaviour:
- Handshake: transfer occurs when val && rdy at a rising edge; val must not depend on rdy.
- Grant: among asserted req_val, choose the first port at or after priority pointer ptr (wrapping NUM_PORTS-1 -> 0). Combinational, one-hot.
- req_rdy[i] = grant[i] && (!out_val || mem_req_rdy) && (count < MAX_INFLIGHT). Non-granted ports always see 0.
- On accept from port g:
  - ptr <= (g+1) mod NUM_PORTS.
  - Packet is captured into the output register; mem_req_* are driven from it next cycle (1-cycle latency).
  - g is pushed into the ID FIFO.
- ptr is unchanged on cycles with no accept.
- Output register:
  - out_val is cleared on a mem_req handshake with no new accept.
  - On a simultaneous drain and accept, it is reloaded with the new packet (full throughput, one packet per cycle).
  - Held stable while mem_req_val && !mem_req_rdy.
- ID FIFO:
  - Depth MAX_INFLIGHT, count width $clog2(MAX_INFLIGHT+1).
  - Tracks requests accepted but not yet responded to. Every type, WRITE included, expects exactly one response.
  - When count == MAX_INFLIGHT, all req_rdy are 0, even if a pop happens the same cycle.
  - Push and pop in the same cycle (count < MAX) leave count unchanged.
  - Pointers wrap modulo MAX_INFLIGHT.
- Response routing, with FIFO head h and count > 0:
  - resp_val = mem_resp_val << h.
  - mem_resp_rdy = resp_rdy[h].
  - resp_type and resp_data are passed through combinationally.
  - Pop on mem_resp handshake.
- Empty FIFO with mem_resp_val = 1 (protocol violation): resp_val = 0, mem_resp_rdy = 1, response discarded, count stays 0.
- Reset, including mid-transfer:
  - Next edge: out_val = 0, ptr = 0, FIFO empty (count = 0, pointers 0).
  - Outputs are 0: mem_req_val, mem_req_type/addr/len/data, resp_val, mem_resp_rdy.
  - Outstanding transactions are abandoned without responses.
- Type and len values are forwarded unchanged; no checking of reserved encodings.

Decomposition:
- memory_types_pkg gains:
  - localparams MEM_TYPE_W = 3 and MEM_LEN_W = 2.
  - enum mem_len_e (BYTE = 0, HALF = 1, WORD = 2).
- mem_pkt_type_e READ/WRITE is reused.
- Sub-module mem_id_fifo (parameters WIDTH = $clog2(NUM_PORTS), DEPTH = MAX_INFLIGHT; push/pop/full/empty/head/count), instantiated once.

Test Plan:
1. Assert rst 2 cycles with all req_val = 1 -> all outputs 0 during reset. Cycle after deassert: req_rdy = 2'b01 (ptr = 0), mem_req_val = 0.
2. NUM_PORTS = 2, both ports valid continuously, mem_req_rdy = 1, port0 addr 0x10/0x14, port1 addr 0x20/0x24, responses returned immediately -> mem_req_addr sequence 0x10, 0x20, 0x14, 0x24, one per cycle after 1-cycle latency.
3. mem_req_rdy = 0 for 3 cycles with mem_req_addr = 0x40 held -> mem_req_* stable, req_rdy = 0 throughout. On release, 0x40 transfers once and the next grant proceeds.
4. MAX_INFLIGHT = 4, no responses, port0 issues 5 READs -> 4 accepted, 5th stalls (req_rdy[0] = 0). One mem_resp handshake -> 5th accepted the cycle after the pop.
5. Port1 READ 0x100, then port0 WRITE 0x200 data 0xDEADBEEF. Memory responds READ data 0xCAFEF00D then WRITE -> resp_val = 2'b10 with resp_data 0xCAFEF00D, then 2'b01 with resp_type WRITE. With resp_rdy[1] = 0 for 2 cycles, mem_resp_rdy = 0 and the response is held.
6. Assert rst with 3 in flight and out_val = 1 -> next cycle count = 0, mem_req_val = 0, ptr = 0. A following mem_resp_val = 1 is discarded with mem_resp_rdy = 1 and resp_val = 0.
